// File: rtl/max_pool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : max_pool_stream
//  Description : Streaming KxK / stride-S max-pooling over raster-ordered
//                pixels using K-1 line buffers and a KxK window register.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_pool_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 299,
    parameter int IMG_HEIGHT = 299,
    parameter int K          = 3,
    parameter int STRIDE     = 2,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int c_CW    = $clog2(IMG_WIDTH);
    localparam int c_RW    = $clog2(IMG_HEIGHT);
    localparam int c_PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int c_OUT_W = (IMG_WIDTH - K) / STRIDE + 1;
    localparam int c_OUT_H = (IMG_HEIGHT - K) / STRIDE + 1;

    localparam logic [c_CW-1:0] c_COL_MAX  = c_CW'(IMG_WIDTH - 1);
    localparam logic [c_CW-1:0] c_COL_KM1  = c_CW'(K - 1);
    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(K - 1 + (c_OUT_W - 1) * STRIDE);
    localparam logic [c_RW-1:0] c_ROW_MAX  = c_RW'(IMG_HEIGHT - 1);
    localparam logic [c_RW-1:0] c_ROW_KM1  = c_RW'(K - 1);
    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(K - 1 + (c_OUT_H - 1) * STRIDE);
    localparam logic [c_PW-1:0] c_PH_MAX   = c_PW'(STRIDE - 1);

    function automatic logic [DATA_WIDTH-1:0] f_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic w_gt;
        if (SIGNED != 0) w_gt = $signed(a) > $signed(b);
        else             w_gt = a > b;
        return w_gt ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // Position and stride-phase counters
    // ------------------------------------------------------------------
    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic [c_PW-1:0] r_cph;
    logic [c_PW-1:0] r_rph;
    logic            w_done;
    logic            w_last;

    // Phases restart at K-1 so that phase 0 marks a window-aligned position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_cph <= '0;
            r_rph <= '0;
        end else if (Valid_In) begin
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_cph <= '0;
                if (r_row == c_ROW_MAX) begin
                    r_row <= '0;
                    r_rph <= '0;
                end else begin
                    r_row <= r_row + c_RW'(1);
                    if (r_row < c_ROW_KM1)       r_rph <= '0;
                    else if (r_rph == c_PH_MAX)  r_rph <= '0;
                    else                         r_rph <= r_rph + c_PW'(1);
                end
            end else begin
                r_col <= r_col + c_CW'(1);
                if (r_col < c_COL_KM1)       r_cph <= '0;
                else if (r_cph == c_PH_MAX)  r_cph <= '0;
                else                         r_cph <= r_cph + c_PW'(1);
            end
        end
    end

    assign w_done = Valid_In && (r_row >= c_ROW_KM1) && (r_col >= c_COL_KM1) &&
                    (r_cph == '0) && (r_rph == '0);
    assign w_last = w_done && (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    // ------------------------------------------------------------------
    // Line buffers: w_col[j] is the pixel j rows above the incoming one
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_col [K];

    assign w_col[0] = Data_In;

    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        logic [DATA_WIDTH-1:0] r_mem [IMG_WIDTH];

        always_ff @(posedge clk) begin
            if (Valid_In) begin
                r_mem[0] <= w_col[g];
                for (int n = 1; n < IMG_WIDTH; n++) begin
                    r_mem[n] <= r_mem[n-1];
                end
            end
        end

        assign w_col[g+1] = r_mem[IMG_WIDTH-1];
    end

    // ------------------------------------------------------------------
    // KxK window register, newest column at index 0
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_win [K][K];

    always_ff @(posedge clk) begin
        if (Valid_In) begin
            for (int j = 0; j < K; j++) begin
                r_win[j][0] <= w_col[j];
                for (int i = 1; i < K; i++) begin
                    r_win[j][i] <= r_win[j][i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-stage max tree, free-running with a parallel valid pipeline
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rowmax [K];
    logic [DATA_WIDTH-1:0] r_rowmax [K];
    logic [DATA_WIDTH-1:0] w_winmax;

    always_comb begin
        for (int j = 0; j < K; j++) begin
            w_rowmax[j] = r_win[j][0];
            for (int i = 1; i < K; i++) begin
                w_rowmax[j] = f_max(w_rowmax[j], r_win[j][i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < K; j++) begin
            r_rowmax[j] <= w_rowmax[j];
        end
    end

    always_comb begin
        w_winmax = r_rowmax[0];
        for (int j = 1; j < K; j++) begin
            w_winmax = f_max(w_winmax, r_rowmax[j]);
        end
    end

    logic r_win_v;
    logic r_win_last;
    logic r_s1_v;
    logic r_s1_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_v    <= 1'b0;
            r_win_last <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s1_last  <= 1'b0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            Data_Out   <= '0;
        end else begin
            r_win_v    <= w_done;
            r_win_last <= w_last;
            r_s1_v     <= r_win_v;
            r_s1_last  <= r_win_last;
            Valid_Out  <= r_s1_v;
            Frame_Done <= r_s1_v & r_s1_last;
            if (r_s1_v) begin
                Data_Out <= w_winmax;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_max_pool_stream
//  Description : Directed self-checking bench for max_pool_stream across five
//                parameter sets sharing one stimulus bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic        v_in;
    int          sel;

    always #5 clk = ~clk;

    logic [31:0] do_a, do_d, do_e;
    logic [7:0]  do_b, do_c;
    logic        vo_a, vo_b, vo_c, vo_d, vo_e;
    logic        fd_a, fd_b, fd_c, fd_d, fd_e;

    max_pool_stream #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3), .STRIDE(2), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .Data_In(d_in), .Valid_In(v_in && sel == 0),
        .Data_Out(do_a), .Valid_Out(vo_a), .Frame_Done(fd_a));
    max_pool_stream #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .K(2), .STRIDE(2), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .Data_In(d_in[7:0]), .Valid_In(v_in && sel == 1),
        .Data_Out(do_b), .Valid_Out(vo_b), .Frame_Done(fd_b));
    max_pool_stream #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .K(2), .STRIDE(2), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst), .Data_In(d_in[7:0]), .Valid_In(v_in && sel == 2),
        .Data_Out(do_c), .Valid_Out(vo_c), .Frame_Done(fd_c));
    max_pool_stream #(.DATA_WIDTH(32), .IMG_WIDTH(7), .IMG_HEIGHT(7), .K(3), .STRIDE(1), .SIGNED(1)) u_d (
        .clk(clk), .rst(rst), .Data_In(d_in), .Valid_In(v_in && sel == 3),
        .Data_Out(do_d), .Valid_Out(vo_d), .Frame_Done(fd_d));
    max_pool_stream #(.DATA_WIDTH(32), .IMG_WIDTH(6), .IMG_HEIGHT(6), .K(3), .STRIDE(2), .SIGNED(0)) u_e (
        .clk(clk), .rst(rst), .Data_In(d_in), .Valid_In(v_in && sel == 4),
        .Data_Out(do_e), .Valid_Out(vo_e), .Frame_Done(fd_e));

    logic [31:0] o_data;
    logic        o_valid;
    logic        o_fd;

    always_comb begin
        o_data  = do_a;
        o_valid = vo_a;
        o_fd    = fd_a;
        case (sel)
            1: begin o_data = {24'd0, do_b}; o_valid = vo_b; o_fd = fd_b; end
            2: begin o_data = {24'd0, do_c}; o_valid = vo_c; o_fd = fd_c; end
            3: begin o_data = do_d;          o_valid = vo_d; o_fd = fd_d; end
            4: begin o_data = do_e;          o_valid = vo_e; o_fd = fd_e; end
            default: ;
        endcase
    end

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          fd_cnt = 0;
    bit          mon_en = 1'b0;
    int          q_t[$];
    bit          q_l[$];
    logic [31:0] q_v[$];
    int          e_t;
    bit          e_l;
    logic [31:0] e_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every output is matched against the next expected value, cycle and frame flag
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_fd) fd_cnt++;
            if (o_valid) begin
                if (q_t.size() == 0 || q_v.size() == 0) begin
                    check("unexpected_valid", {31'd0, o_valid}, 32'd0);
                end else begin
                    e_t = q_t.pop_front();
                    e_l = q_l.pop_front();
                    e_v = q_v.pop_front();
                    check("data", o_data, e_v);
                    check("latency", cyc, e_t);
                    check("frame_done", {31'd0, o_fd}, {31'd0, e_l});
                end
            end else begin
                check("stray_frame_done", {31'd0, o_fd}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] pix(input int mode, input int r, input int c, input int w);
        case (mode)
            0:       return 32'(r * w + c);
            1:       return 32'd0;
            2:       return ((r % 2 == 0) && (c % 2 == 1)) ? 32'd5 : 32'hFF;
            default: return ((r % 2 == 1) && (c % 2 == 0)) ? 32'hFF : 32'h9C;
        endcase
    endfunction

    task automatic drive(input int w, input int h, input int k, input int s,
                         input int mode, input int gap, input int npix);
        int  idx;
        int  lr;
        int  lc;
        int  ng;
        bit  cmp;
        idx = 0;
        lr  = k - 1 + ((h - k) / s) * s;
        lc  = k - 1 + ((w - k) / s) * s;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (idx < npix) begin
                    ng = 0;
                    while (gap > 0 && ng < 8 && $urandom_range(99) < gap) begin
                        v_in = 1'b0;
                        ng++;
                        @(posedge clk); #1;
                    end
                    d_in = pix(mode, r, c, w);
                    v_in = 1'b1;
                    @(posedge clk); #1;
                    cmp = (r >= k - 1) && (c >= k - 1) &&
                          ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
                    if (cmp) begin
                        q_t.push_back(cyc + 2);
                        q_l.push_back((r == lr) && (c == lc));
                    end
                    idx++;
                end
            end
        end
        v_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_pending"}, q_t.size(), 0);
        check({tag, "_unseen"}, q_v.size(), 0);
    endtask

    task automatic push4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        q_v.push_back(a); q_v.push_back(b); q_v.push_back(c); q_v.push_back(d);
    endtask

    task automatic pulse_rst(input bit with_valid);
        rst  = 1'b1;
        v_in = with_valid;
        d_in = 32'd99;
        @(posedge clk); #1;
        rst  = 1'b0;
        v_in = 1'b0;
        q_t.delete();
        q_l.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        v_in = 1'b0;
        d_in = 32'd0;
        sel  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", o_data, 32'd0);
        check("reset_valid", {31'd0, o_valid}, 32'd0);
        check("reset_fd", {31'd0, o_fd}, 32'd0);
        check("reset_data_b", {24'd0, do_b}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 5x5 ramp, continuous then with gaps
        fd_cnt = 0;
        push4(12, 14, 22, 24);
        drive(5, 5, 3, 2, 0, 0, 25);
        drain("ramp5");
        check("ramp5_fd_count", fd_cnt, 1);
        check("ramp5_hold", o_data, 32'd24);

        fd_cnt = 0;
        push4(12, 14, 22, 24);
        drive(5, 5, 3, 2, 0, 35, 25);
        drain("ramp5_gaps");
        check("ramp5_gaps_fd_count", fd_cnt, 1);

        // Signed versus unsigned compare on 8-bit pixels
        sel = 1;
        push4(32'hFF, 32'hFF, 32'hFF, 32'hFF);
        drive(4, 4, 2, 2, 3, 0, 16);
        drain("signed_m100");
        push4(5, 5, 5, 5);
        drive(4, 4, 2, 2, 2, 0, 16);
        drain("signed_m1_5");
        sel = 2;
        push4(32'hFF, 32'hFF, 32'hFF, 32'hFF);
        drive(4, 4, 2, 2, 2, 0, 16);
        drain("unsigned_m1_5");

        // Back-to-back 7x7 frames, stride 1; second frame is all zero
        sel    = 3;
        fd_cnt = 0;
        for (int r = 2; r < 7; r++)
            for (int c = 2; c < 7; c++)
                q_v.push_back(32'(r * 7 + c));
        for (int i = 0; i < 25; i++) q_v.push_back(32'd0);
        drive(7, 7, 3, 1, 0, 0, 49);
        drive(7, 7, 3, 1, 1, 0, 49);
        drain("b2b7");
        check("b2b7_fd_count", fd_cnt, 2);

        // Reset while a window is in flight, with Valid_In high during reset
        sel = 0;
        drive(5, 5, 3, 2, 0, 0, 13);
        pulse_rst(1'b1);
        fd_cnt = 0;
        push4(12, 14, 22, 24);
        drive(5, 5, 3, 2, 0, 0, 25);
        drain("rst_inflight");
        check("rst_inflight_fd_count", fd_cnt, 1);

        // Reset after pixel (3,1), then a fresh frame
        q_v.push_back(12);
        q_v.push_back(14);
        drive(5, 5, 3, 2, 0, 0, 17);
        pulse_rst(1'b0);
        check("rst31_unseen", q_v.size(), 0);
        push4(12, 14, 22, 24);
        drive(5, 5, 3, 2, 0, 0, 25);
        drain("rst31");

        // 6x6 with trailing row/column discarded, two frames back to back
        sel    = 4;
        fd_cnt = 0;
        push4(14, 16, 26, 28);
        push4(14, 16, 26, 28);
        drive(6, 6, 3, 2, 0, 0, 36);
        drive(6, 6, 3, 2, 0, 0, 36);
        drain("trail6");
        check("trail6_fd_count", fd_cnt, 2);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/max_pool_stream.md
# max_pool_stream

Parametrised streaming max-pooling engine for raster-ordered feature maps: it accepts one pixel per valid beat, keeps K-1 line buffers plus a K×K window register, and emits the maximum of every K×K window placed at stride S. It supersedes the fixed 3×3/stride-2, 299×299 pooling path. It adds configurable kernel, stride, size and width, signed or unsigned compare, input stalls, and a frame-done marker. It sits between a convolution output stream and the next layer's input stream.

## Interface
- DATA_WIDTH, 32: pixel width in bits.
- IMG_WIDTH, 299: input columns per row (≥ K).
- IMG_HEIGHT, 299: input rows per frame (≥ K).
- K, 3: square kernel size, legal 2..5.
- STRIDE, 2: horizontal and vertical stride, legal 1..K.
- SIGNED, 1: 1 = two's-complement compare, 0 = unsigned compare.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Data_In  in  DATA_WIDTH  input pixel, raster order (row-major, top-left first).
- Valid_In  in  1  Data_In is a pixel this cycle; may deassert at any cycle (gaps allowed).
- Data_Out  out  DATA_WIDTH  pooled pixel.
- Valid_Out  out  1  Data_Out valid this cycle; single-cycle pulse per output.
- Frame_Done  out  1  one-cycle pulse coincident with Valid_Out of the last output pixel of a frame.

## Operation
- Output size: OUT_W = (IMG_WIDTH-K)/STRIDE+1, OUT_H = (IMG_HEIGHT-K)/STRIDE+1 (integer floor). Trailing columns and rows that cannot fill a window are consumed and discarded.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on Valid_In. col wraps to 0 with row++. After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0, and the next pixel starts a new frame with no idle cycle required.
- Stride phase counters cph and rph (0..STRIDE-1) track alignment. A window is complete on the accepted pixel (row, col) when row ≥ K-1, col ≥ K-1, (row-(K-1)) mod STRIDE = 0 and (col-(K-1)) mod STRIDE = 0. This is implemented with phase counters, not a divider.
- Line buffers: K-1 RAM/shift stages, each IMG_WIDTH deep. They shift only on Valid_In. The window columns shift in the new column (K pixels: line-buffer taps plus Data_In) on every Valid_In.
- Max tree: stage 1 registers the per-row maximum of K pixels. Stage 2 registers the maximum of the K row maxima. Comparison is signed or unsigned per SIGNED. Ties yield the common value.
- Window contents from a previous row or frame are never output. Gating by row/col counters alone guarantees this, so line buffers need no clear.

## Timing
- Latency: Valid_Out rises exactly 2 cycles after the clk edge that accepts the window-completing pixel. This holds regardless of Valid_In gaps after that pixel, because the max pipeline is free-running with a valid bit.
- Throughput: one pixel per cycle in. At most one output per input beat.
- Frame_Done is asserted in the same cycle as Valid_Out for window (OUT_H-1, OUT_W-1). It is 0 otherwise.
- Reset values: Data_Out = 0, Valid_Out = 0, Frame_Done = 0. row, col, cph, rph and the pipeline valid bits are all 0. Line-buffer contents are don't-care.
- rst mid-frame: in-flight pipeline valids are dropped, so there is no Valid_Out on the 2 cycles after rst. The next Valid_In beat after rst deasserts is treated as pixel (0,0).
- rst asserted together with Valid_In: reset wins and the pixel is discarded.
- Data_Out holds its last value when Valid_Out = 0. Consumers sample only on Valid_Out.
- No backpressure: the downstream block must accept every Valid_Out pulse.

## Test plan
- 5×5, K=3, S=2, SIGNED=0, pixel value r*5+c, Valid_In continuous: exactly 4 outputs 12, 14, 22, 24. Each appears 2 cycles after accepting pixels (2,2), (2,4), (4,2), (4,4). Frame_Done pulses with 24.
- Same frame with Valid_In randomly deasserted (≥30% gaps): identical output sequence. Each output still appears 2 cycles after its completing pixel.
- SIGNED=1, DATA_WIDTH=8, 4×4, K=2, S=2, all pixels -100 except one -1 in each 2×2 block: 4 outputs all 0xFF. With SIGNED=0 on the same data, outputs are 0x9C where -100 exceeds -1 unsigned? No: unsigned max is 0xFF too. Use values -1 (0xFF) vs 5 instead: SIGNED=1 gives 5, SIGNED=0 gives 0xFF.
- 7×7, K=3, S=1, two back-to-back frames with no gap: 25 outputs per frame and exactly 2 Frame_Done pulses. The first output of frame 2 contains no frame-1 data (frame 2 is a constant 0, so its outputs are all 0).
- rst for 1 cycle after pixel (3,1) of a 5×5, K=3, S=2 frame, then a full fresh ramp frame: no Valid_Out within 2 cycles after rst. The fresh frame gives exactly 12, 14, 22, 24.
- 6×6, K=3, S=2 (trailing row and column discarded): outputs are the windows at rows/cols 0 and 2 only, 4 outputs. With value r*6+c these are 14, 16, 26, 28. Frame_Done pulses with 28, and the following pixel is treated as (0,0).
